// File: rtl/minimization_sweep_ctrl.sv
// Sweeps the 4-bit minimization datapath input over a code range, samples each result and folds it into a signature.
// Optional golden-model checking is enabled by defining MINIMIZATION_SWEEP_CHECK_EN.
module minimization_sweep_ctrl #(
  parameter int unsigned START_CODE = 0,
  parameter int unsigned END_CODE   = 15,
  parameter int unsigned SETTLE     = 1,
  localparam int unsigned CODE_W    = 4,
  localparam int unsigned DATA_W    = 3,
  localparam int unsigned SIG_W     = 8,
  localparam int unsigned CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [CODE_W-1:0] dp_in,
  input  logic [DATA_W-1:0] dp_out,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [CODE_W-1:0] res_code,
  output logic [DATA_W-1:0] res_data,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              err
);

  localparam logic [CODE_W-1:0] START_C  = CODE_W'(START_CODE);
  localparam logic [CODE_W-1:0] END_C    = CODE_W'(END_CODE);
  localparam logic [CODE_W-1:0] SETTLE_C = CODE_W'(SETTLE);
  localparam bit                SKIP_SETTLE = (SETTLE_C == '0);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  wait_q, wait_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               res_valid_q, res_valid_d;
  logic [CODE_W-1:0]  res_code_q, res_code_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic [SIG_W-1:0]   sig_q, sig_d;

  // Sequencing: settle countdown, sample, advance code, finish.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = 1'b0;
    res_code_d  = res_code_q;
    res_data_d  = res_data_q;
    sig_d       = sig_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
          code_d  = START_C;
          wait_d  = SETTLE_C;
          busy_d  = 1'b1;
          sig_d   = '0;
        end
      end
      S_SETTLE: begin
        wait_d = wait_q - CODE_W'(1);
        if (wait_q <= CODE_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        res_valid_d = 1'b1;
        res_code_d  = code_q;
        res_data_d  = dp_out;
        sig_d       = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(dp_out);
        if (code_q == END_C) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          code_d  = code_q + CODE_W'(1);
          wait_d  = SETTLE_C;
          state_d = SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= '0;
      res_data_q  <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_data_q  <= res_data_d;
      sig_q       <= sig_d;
    end
  end

  assign dp_in     = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_code  = res_code_q;
  assign res_data  = res_data_q;
  assign signature = sig_q;

`ifdef MINIMIZATION_SWEEP_CHECK_EN
  logic              start_acc;
  logic              sample_en;
  logic [DATA_W-1:0] golden;
  logic [CNT_W-1:0]  mm_q, mm_d;
  logic              err_q, err_d;

  assign start_acc = (state_q == S_IDLE) && start;
  assign sample_en = (state_q == S_SAMPLE);

  // Golden model of the datapath evaluated on the code currently driven.
  always_comb begin
    golden = {code_q[1] ^ code_q[0], ~(code_q[1] ^ code_q[0]), code_q[0]};
    mm_d   = mm_q;
    err_d  = err_q;
    if (start_acc) begin
      mm_d  = '0;
      err_d = 1'b0;
    end else if (sample_en && (dp_out != golden)) begin
      if (mm_q != '1) mm_d = mm_q + CNT_W'(1);
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm_q  <= '0;
      err_q <= 1'b0;
    end else begin
      mm_q  <= mm_d;
      err_q <= err_d;
    end
  end

  assign mismatch_cnt = mm_q;
  assign err          = err_q;
`else
  assign mismatch_cnt = '0;
  assign err          = 1'b0;
`endif

endmodule
